// File: rtl/mem_port_master_if.sv
// mem_port_master_if: request/response and memory-pin bundle for the CPU memory port master
interface mem_port_master_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 24,
    parameter int WDATA_W = 8
);
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               data_req;
    logic               data_we;
    logic [ADDR_W-1:0]  data_addr;
    logic [WDATA_W-1:0] data_wdata;
    logic               busy;
    logic               fetch_valid;
    logic [DATA_W-1:0]  instr;
    logic               data_valid;
    logic [DATA_W-1:0]  rdata;
    logic               align_err;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [WDATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    modport master (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        output busy, fetch_valid, instr, data_valid, rdata, align_err, mem_addr, mem_we, mem_wdata
    );
    modport slave (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        input  busy, fetch_valid, instr, data_valid, rdata, align_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_master.sv
// mem_port_master: single-transaction fetch/load/store controller for a registered-read memory
module mem_port_master #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 24,
    parameter int WDATA_W      = 8,
    parameter int READ_LATENCY = 1
) (
    input logic clk,
    input logic rst_n,
    mem_port_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;
    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);
    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               fetch_q, fetch_d;
    logic               busy_q, busy_d;
    logic               fvalid_q, fvalid_d;
    logic               dvalid_q, dvalid_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               align_q, align_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [WDATA_W-1:0] wdata_q, wdata_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fetch_d  = fetch_q;
        busy_d   = busy_q;
        fvalid_d = 1'b0;
        dvalid_d = 1'b0;
        instr_d  = instr_q;
        rdata_d  = rdata_q;
        align_d  = align_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                we_d = bus.data_req & bus.data_we;
                if (bus.data_req | bus.fetch_req) begin
                    state_d = WAIT;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                    fetch_d = ~bus.data_req;
                    addr_d  = bus.data_req ? bus.data_addr : bus.fetch_addr;
                    wdata_d = bus.data_req ? bus.data_wdata : '0;
                    align_d = align_q | (~bus.data_req & (bus.fetch_addr[1:0] != 2'b00));
                end
            end
            WAIT: begin
                we_d    = 1'b0;
                state_d = (cnt_q == 3'd0) ? CAPTURE : WAIT;
                cnt_d   = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
            end
            CAPTURE: begin
                instr_d  = fetch_q ? bus.mem_rdata : instr_q;
                rdata_d  = fetch_q ? rdata_q : bus.mem_rdata;
                fvalid_d = fetch_q;
                dvalid_d = ~fetch_q;
                busy_d   = 1'b0;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fetch_q  <= 1'b0;
            busy_q   <= 1'b0;
            fvalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            instr_q  <= '0;
            rdata_q  <= '0;
            align_q  <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fetch_q  <= fetch_d;
            busy_q   <= busy_d;
            fvalid_q <= fvalid_d;
            dvalid_q <= dvalid_d;
            instr_q  <= instr_d;
            rdata_q  <= rdata_d;
            align_q  <= align_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end
    assign bus.busy        = busy_q;
    assign bus.fetch_valid = fvalid_q;
    assign bus.data_valid  = dvalid_q;
    assign bus.instr       = instr_q;
    assign bus.rdata       = rdata_q;
    assign bus.align_err   = align_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: randomized self-checking bench against a word-array memory reference model
module tb_mem_port_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    mem_port_master_if b1 ();
    mem_port_master_if b3 ();
    mem_port_master #(.READ_LATENCY(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
    mem_port_master #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    logic [23:0] mem [256];
    logic [23:0] ref_mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [23:0] bd_data = '0;
    logic [23:0] p1;
    logic [23:0] p3 [3];
    // memory device: registered read of old contents, write lands on the same edge
    always @(posedge clk) begin
        p1 <= mem[b1.mem_addr];
        p3[0] <= mem[b3.mem_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (b1.mem_we) mem[b1.mem_addr] <= {16'h0, b1.mem_wdata};
    end
    assign b1.mem_rdata = p1;
    assign b3.mem_rdata = p3[2];

    task automatic preload();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bd_we = 1'b1;
            bd_addr = 8'(i);
            bd_data = (i == 8'h80) ? 24'h040207 : (i == 8'h10) ? 24'h123456 : 24'($urandom);
            ref_mem[i] = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({b1.busy, b1.fetch_valid, b1.data_valid, b1.instr, b1.rdata, b1.align_err,
             b1.mem_addr, b1.mem_we, b1.mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b mem_we=%b instr=%h rdata=%h mem_addr=%h want all 0",
                     b1.busy, b1.mem_we, b1.instr, b1.rdata, b1.mem_addr);
        end
        tests++;
        if ({b3.busy, b3.fetch_valid, b3.instr, b3.align_err, b3.mem_we} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_rl3: busy=%b valid=%b instr=%h want 0", b3.busy, b3.fetch_valid, b3.instr);
        end
    endtask

    // caller is at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle
    task automatic run_txn(input bit f, input bit we, input logic [7:0] a, input logic [7:0] wd);
        int n, busy_n, we_n;
        bit seen;
        logic [23:0] exp;
        exp = ref_mem[a];
        b1.fetch_req = f; b1.fetch_addr = a;
        b1.data_req = !f; b1.data_we = we; b1.data_addr = a; b1.data_wdata = wd;
        n = 0; busy_n = 0; we_n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            busy_n += int'(b1.busy);
            if (b1.mem_we) begin
                we_n++;
                tests++;
                if (b1.mem_addr !== a || b1.mem_wdata !== wd) begin
                    fails++;
                    $display("FAIL mem_write_pins: addr=%h wdata=%h want %h %h", b1.mem_addr, b1.mem_wdata, a, wd);
                end
            end
            seen = f ? b1.fetch_valid : b1.data_valid;
        end
        b1.fetch_req = 1'b0; b1.data_req = 1'b0;
        tests++;
        if (n != 3) begin fails++; $display("FAIL latency: got %0d negedges want 3 (a=%h)", n, a); end
        tests++;
        if ((f ? b1.instr : b1.rdata) !== exp) begin
            fails++;
            $display("FAIL read_word: f=%0d a=%h got %h want %h", f, a, f ? b1.instr : b1.rdata, exp);
        end
        tests++;
        if (busy_n != 2) begin fails++; $display("FAIL busy_cycles: got %0d want 2", busy_n); end
        tests++;
        if (we_n != int'(!f && we)) begin fails++; $display("FAIL we_pulse: got %0d want %0d", we_n, int'(!f && we)); end
        if (!f && we) ref_mem[a] = {16'h0, wd};
        @(negedge clk);
        tests++;
        if (b1.fetch_valid || b1.data_valid || b1.busy) begin
            fails++;
            $display("FAIL pulse_width: fv=%b dv=%b busy=%b want 0", b1.fetch_valid, b1.data_valid, b1.busy);
        end
    endtask

    task automatic test_fetch();
        run_txn(1'b1, 1'b0, 8'h80, 8'h0);
        for (int i = 0; i < 6; i++) run_txn(1'b1, 1'b0, 8'($urandom_range(0, 255)) & 8'hFC, 8'h0);
    endtask

    task automatic test_store_load();
        logic [7:0] a;
        run_txn(1'b0, 1'b1, 8'h01, 8'h0A);
        run_txn(1'b0, 1'b0, 8'h01, 8'h0);
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            run_txn(1'b0, 1'b1, a, 8'($urandom));
            run_txn(1'b0, 1'b0, a, 8'h0);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        t0 = $time;
        for (int i = 0; i < 8; i++)
            run_txn(i[0], 1'($urandom), 8'($urandom_range(0, 255)) & (i[0] ? 8'hFC : 8'hFF), 8'($urandom));
        tests++;
        if ($time - t0 != 8 * 4 * 10) begin
            fails++;
            $display("FAIL throughput: got %0t for 8 txns want %0d", $time - t0, 8 * 4 * 10);
        end
    endtask

    task automatic test_priority();
        int n;
        bit early;
        logic [23:0] exp_d, exp_f;
        exp_d = ref_mem[8'h10]; exp_f = ref_mem[8'h40];
        b1.data_req = 1'b1; b1.data_we = 1'b0; b1.data_addr = 8'h10;
        b1.fetch_req = 1'b1; b1.fetch_addr = 8'h40;
        n = 0; early = 1'b0;
        while (!b1.data_valid && n < 20) begin
            @(negedge clk);
            n++;
            early |= b1.fetch_valid;
        end
        b1.data_req = 1'b0;
        tests++;
        if (early || n != 3) begin fails++; $display("FAIL prio_load_first: n=%0d fetch_early=%0d want 3 0", n, early); end
        tests++;
        if (b1.rdata !== exp_d) begin fails++; $display("FAIL prio_rdata: got %h want %h", b1.rdata, exp_d); end
        n = 0;
        while (!b1.fetch_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        b1.fetch_req = 1'b0;
        tests++;
        if (n != 4) begin fails++; $display("FAIL prio_fetch_gap: got %0d want 4", n); end
        tests++;
        if (b1.instr !== exp_f) begin fails++; $display("FAIL prio_instr: got %h want %h", b1.instr, exp_f); end
        @(negedge clk);
    endtask

    task automatic test_align();
        tests++;
        if (b1.align_err !== 1'b0) begin fails++; $display("FAIL align_pre: got %b want 0", b1.align_err); end
        run_txn(1'b1, 1'b0, 8'h82, 8'h0);
        tests++;
        if (b1.align_err !== 1'b1) begin fails++; $display("FAIL align_set: got %b want 1", b1.align_err); end
        run_txn(1'b1, 1'b0, 8'h84, 8'h0);
        tests++;
        if (b1.align_err !== 1'b1) begin fails++; $display("FAIL align_sticky: got %b want 1", b1.align_err); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        bit any;
        a = 8'($urandom_range(0, 255));
        b1.data_req = 1'b1; b1.data_we = 1'b1; b1.data_addr = a; b1.data_wdata = 8'($urandom);
        @(negedge clk);
        tests++;
        if (b1.busy !== 1'b1 || b1.mem_we !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: busy=%b mem_we=%b want 1 1", b1.busy, b1.mem_we);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({b1.mem_we, b1.busy, b1.fetch_valid, b1.data_valid, b1.align_err, b1.instr} !== '0) begin
            fails++;
            $display("FAIL mid_async: mem_we=%b busy=%b align=%b instr=%h want 0", b1.mem_we, b1.busy, b1.align_err, b1.instr);
        end
        b1.data_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any |= b1.fetch_valid | b1.data_valid | b1.busy;
        end
        tests++;
        if (any) begin fails++; $display("FAIL mid_quiet: activity=%b want 0", any); end
        run_txn(1'b0, 1'b0, a, 8'h0);
    endtask

    task automatic test_latency3();
        int n;
        logic [7:0] a;
        logic [23:0] exp;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 8'h80 : 8'($urandom_range(0, 255)) & 8'hFC;
            exp = ref_mem[a];
            b3.fetch_req = 1'b1; b3.fetch_addr = a;
            n = 0;
            while (!b3.fetch_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            b3.fetch_req = 1'b0;
            tests++;
            if (n != 5) begin fails++; $display("FAIL rl3_latency: got %0d want 5", n); end
            tests++;
            if (b3.instr !== exp) begin fails++; $display("FAIL rl3_instr: a=%h got %h want %h", a, b3.instr, exp); end
            @(negedge clk);
        end
    endtask

    initial begin
        b1.fetch_req = 0; b1.fetch_addr = 0; b1.data_req = 0; b1.data_we = 0; b1.data_addr = 0; b1.data_wdata = 0;
        b3.fetch_req = 0; b3.fetch_addr = 0; b3.data_req = 0; b3.data_we = 0; b3.data_addr = 0; b3.data_wdata = 0;
        preload();
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_fetch();
        test_store_load();
        test_back_to_back();
        test_priority();
        test_align();
        test_reset_mid();
        test_latency3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Requester-side controller for the 256-entry, 24-bit synchronous instruction/data memory of the multi-cycle CPU.
- Accepts instruction-fetch and data load/store requests from the control unit and drives the memory's address, write-enable and write-data pins.
- Waits out the memory's registered read latency, captures the returned 24-bit word and hands it back with a one-cycle valid pulse.
- Single-ported: one memory transaction in flight at a time.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 24, memory read word width (instruction width).
- WDATA_W, 8, memory write-data width. Memory zero-extends writes to DATA_W.
- READ_LATENCY, 1, clock edges between address/we presented to memory and the updated memory output. Range 1..7.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_req  input  1  level request: instruction fetch.
- fetch_addr  input  ADDR_W  fetch address; expected word-aligned (addr[1:0]=0).
- data_req  input  1  level request: data access.
- data_we  input  1  with data_req: 1 = store, 0 = load.
- data_addr  input  ADDR_W  load/store address.
- data_wdata  input  WDATA_W  store data.
- busy  output  1  high from accept until the DONE cycle.
- fetch_valid  output  1  one-cycle pulse: instr is valid.
- instr  output  DATA_W  captured instruction word; holds until the next fetch capture.
- data_valid  output  1  one-cycle pulse: load/store complete; rdata is valid.
- rdata  output  DATA_W  captured data word; holds until the next data capture.
- align_err  output  1  sticky flag: a fetch with fetch_addr[1:0]!=0 was accepted.
- mem_addr  output  ADDR_W  registered address to memory.
- mem_we  output  1  registered write enable to memory.
- mem_wdata  output  WDATA_W  registered write data to memory.
- mem_rdata  input  DATA_W  memory output word.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE.
  - All outputs 0: busy, fetch_valid, data_valid, instr, rdata, align_err, mem_addr, mem_we, mem_wdata.
  - Latency counter = 0.
  - Applies immediately, including mid-transaction; mem_we drops without waiting for a clock edge.
- FSM states: IDLE, WAIT, CAPTURE, DONE.
- IDLE:
  - Samples requests at each edge.
  - data_req has priority over fetch_req.
  - On accept: register mem_addr from the winning address, mem_we=data_req&data_we, mem_wdata=data_wdata (0 for fetch), record the kind (fetch/load/store), busy<=1, cnt<=READ_LATENCY-1, go to WAIT.
  - With no request: stay in IDLE, mem_we=0.
  - A misaligned fetch is still issued and sets align_err<=1. align_err clears only on reset.
- WAIT:
  - mem_we is forced to 0 on the first edge in WAIT, so the write pulse is exactly 1 cycle.
  - mem_addr is held.
  - If cnt==0, go to CAPTURE; else cnt<=cnt-1.
- CAPTURE:
  - Latch mem_rdata into instr (fetch) or rdata (load/store).
  - Store: rdata = pre-write contents, because memory reads before it writes.
  - Assert fetch_valid or data_valid, busy<=0, go to DONE.
- DONE:
  - Valid pulse is high for exactly this cycle; no request is accepted here.
  - Always go to IDLE next.
- Handshake:
  - Requesters hold req and operands stable until their valid pulse.
  - Requesters drop req in the valid cycle; a req still high in the following IDLE cycle is a new request.
  - Operand changes while busy are ignored.
  - The losing request of a simultaneous pair stays held and is accepted in the IDLE cycle after the winner's DONE.
- Timing: with READ_LATENCY=1 the accept edge is t0, capture is at t2, and valid is high during t2..t3. Back-to-back throughput is 4 cycles per transaction.
- Width rules: no address arithmetic, so there is no wrap concern. 0xFF is a legal address.

Test Plan:
- Reset then fetch_req, fetch_addr=0x80, with mem model holding 0x040207 at 0x80 -> fetch_valid pulses 1 cycle, 3 cycles after the accept edge; instr=0x040207; busy high 2 cycles; mem_we never 1.
- Store: data_req=1, data_we=1, data_addr=0x01, data_wdata=0x0A -> mem_we high exactly 1 cycle with mem_addr=0x01, mem_wdata=0x0A; then a load at 0x01 returns rdata=0x00000A.
- fetch_req and data_req (load at 0x10, content 0x123456) asserted on the same edge -> load served first (data_valid, rdata=0x123456); fetch accepted in the IDLE cycle after DONE; fetch_valid exactly 4 cycles after data_valid.
- Fetch at 0x82 -> align_err=1 and stays 1 after a later aligned fetch at 0x84; cleared only by rst_n.
- rst_n pulsed low during WAIT of a store -> mem_we, busy and all valids 0 immediately; after release the FSM is in IDLE with no valid pulse.
- READ_LATENCY=3 -> valid pulse 5 cycles after the accept edge; instr equals memory content at the issued address.
